// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and baud helper used by uart_rx and uart_tx.
package uart_pkg;

   typedef enum logic [2:0] {
      idle,
      start_bit,
      data_bits,
      parity_bit,
      stop_bit,
      cleanup
   } uart_rx_state_t;

   function automatic int calc_clks_per_bit(input int clk_freq, input int baud_rate);
      return clk_freq / baud_rate;
   endfunction

endpackage

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchronizer for asynchronous single-bit inputs.
module uart_sync2 #(
   parameter logic reset_val = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= reset_val;
         q    <= reset_val;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver; define UART_RX_PARITY_EN for an even-parity bit before stop.
module uart_rx
   import uart_pkg::*;
#(
   parameter int clk_freq  = 50000000,
   parameter int baud_rate = 9600
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_busy,
   output logic       frame_err,
   output logic       parity_err
);

   localparam int clks_per_bit = calc_clks_per_bit(clk_freq, baud_rate);
   localparam int half_bit     = clks_per_bit / 2;
   localparam logic [15:0] bit_last  = 16'(clks_per_bit - 1);
   localparam logic [15:0] half_last = 16'(half_bit - 1);

   logic           rx_s;
   uart_rx_state_t state, state_n;
   logic [15:0]    clk_count, clk_count_n;
   logic [2:0]     bit_index, bit_index_n;
   logic [7:0]     shift_reg, shift_n;
   logic [7:0]     data_n;
   logic           valid_n, busy_n, ferr_n;
`ifdef UART_RX_PARITY_EN
   logic           parity_reg, parity_n, perr_n;
`endif

   uart_sync2 #(.reset_val(1'b1)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx),
      .q   (rx_s)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= idle;
         clk_count <= '0;
         bit_index <= '0;
         shift_reg <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         rx_busy   <= 1'b0;
         frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_reg <= 1'b0;
         parity_err <= 1'b0;
`endif
      end else begin
         state     <= state_n;
         clk_count <= clk_count_n;
         bit_index <= bit_index_n;
         shift_reg <= shift_n;
         rx_data   <= data_n;
         rx_valid  <= valid_n;
         rx_busy   <= busy_n;
         frame_err <= ferr_n;
`ifdef UART_RX_PARITY_EN
         parity_reg <= parity_n;
         parity_err <= perr_n;
`endif
      end
   end

`ifndef UART_RX_PARITY_EN
   assign parity_err = 1'b0;
`endif

   always_comb begin
      state_n     = state;
      clk_count_n = clk_count;
      bit_index_n = bit_index;
      shift_n     = shift_reg;
      data_n      = rx_data;
      busy_n      = rx_busy;
      valid_n     = 1'b0;
      ferr_n      = 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_n    = parity_reg;
      perr_n      = 1'b0;
`endif
      case (state)
         idle: begin
            clk_count_n = '0;
            bit_index_n = '0;
            busy_n      = 1'b0;
            if (!rx_s) begin
               state_n = start_bit;
               busy_n  = 1'b1;
            end
         end
         start_bit: begin
            if (clk_count == half_last) begin
               clk_count_n = '0;
               if (!rx_s) begin
                  state_n = data_bits;
               end else begin
                  state_n = idle;
                  busy_n  = 1'b0;
               end
            end else begin
               clk_count_n = clk_count + 16'd1;
            end
         end
         data_bits: begin
            if (clk_count == bit_last) begin
               clk_count_n        = '0;
               shift_n[bit_index] = rx_s;
               bit_index_n        = bit_index + 3'd1;
               if (bit_index == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_n = parity_bit;
`else
                  state_n = stop_bit;
`endif
               end
            end else begin
               clk_count_n = clk_count + 16'd1;
            end
         end
`ifdef UART_RX_PARITY_EN
         parity_bit: begin
            if (clk_count == bit_last) begin
               clk_count_n = '0;
               parity_n    = rx_s;
               state_n     = stop_bit;
            end else begin
               clk_count_n = clk_count + 16'd1;
            end
         end
`endif
         stop_bit: begin
            if (clk_count == bit_last) begin
               clk_count_n = '0;
               busy_n      = 1'b0;
               state_n     = cleanup;
               // Framing error wins over parity; only one strobe per frame.
               if (!rx_s) begin
                  ferr_n = 1'b1;
`ifdef UART_RX_PARITY_EN
               end else if (^{shift_reg, parity_reg}) begin
                  perr_n = 1'b1;
`endif
               end else begin
                  valid_n = 1'b1;
                  data_n  = shift_reg;
               end
            end else begin
               clk_count_n = clk_count + 16'd1;
            end
         end
         cleanup: begin
            busy_n = 1'b0;
            if (rx_s) state_n = idle;
         end
         default: begin
            state_n = idle;
            busy_n  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx at 10 clocks per bit.
module tb_uart_rx;

   localparam int clk_freq  = 1000000;
   localparam int baud_rate = 100000;
   localparam int cpb       = 10;
`ifdef UART_RX_PARITY_EN
   localparam int exp_lat   = 108;
`else
   localparam int exp_lat   = 98;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       rx  = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid, rx_busy, frame_err, parity_err;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int valid_cnt = 0, ferr_cnt = 0, perr_cnt = 0, valid_cycle = 0, start_cycle = 0;
   logic [7:0] rx_q[$];
   logic busy_at_valid = 1'b1;
   logic busy_mid = 1'b0;
`ifdef UART_RX_PARITY_EN
   logic par_flip_g = 1'b0;
`endif

   uart_rx #(.clk_freq(clk_freq), .baud_rate(baud_rate)) dut (
      .clk        (clk),
      .rst        (rst),
      .rx         (rx),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_busy    (rx_busy),
      .frame_err  (frame_err),
      .parity_err (parity_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rx_valid) begin
         valid_cnt++;
         rx_q.push_back(rx_data);
         valid_cycle = cyc;
         busy_at_valid = rx_busy;
      end
      if (frame_err) ferr_cnt++;
      if (parity_err) perr_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive_bit(input logic b);
      rx = b;
      wait_cycles(cpb);
   endtask

   task automatic send_byte(input logic [7:0] d, input logic stop_val);
      start_cycle = cyc;
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) begin
         if (i == 4) busy_mid = rx_busy;
         drive_bit(d[i]);
      end
`ifdef UART_RX_PARITY_EN
      drive_bit((^d) ^ par_flip_g);
`endif
      drive_bit(stop_val);
   endtask

   initial begin
      #2 rst = 1'b1;
      wait_cycles(3);
      check("reset_rx_data", 32'(rx_data), 32'h00);
      check("reset_rx_valid", 32'(rx_valid), 32'h0);
      check("reset_rx_busy", 32'(rx_busy), 32'h0);
      check("reset_frame_err", 32'(frame_err), 32'h0);
      check("reset_parity_err", 32'(parity_err), 32'h0);
      rst = 1'b0;
      wait_cycles(5);

      // single frame 0xA5
      send_byte(8'hA5, 1'b1);
      wait_cycles(5);
      check("a5_valid_count", 32'(valid_cnt), 32'd1);
      check("a5_data", 32'(rx_data), 32'hA5);
      check("a5_frame_err", 32'(ferr_cnt), 32'd0);
      check("a5_latency_window", 32'((valid_cycle - start_cycle) >= exp_lat - 2 &&
                                     (valid_cycle - start_cycle) <= exp_lat + 2), 32'd1);
      check("a5_busy_mid", 32'(busy_mid), 32'd1);
      check("a5_busy_at_valid", 32'(busy_at_valid), 32'd0);

      // back-to-back frames, no idle gap
      send_byte(8'h00, 1'b1);
      send_byte(8'hFF, 1'b1);
      send_byte(8'h55, 1'b1);
      wait_cycles(5);
      check("b2b_valid_count", 32'(valid_cnt), 32'd4);
      check("b2b_byte0", 32'(rx_q[1]), 32'h00);
      check("b2b_byte1", 32'(rx_q[2]), 32'hFF);
      check("b2b_byte2", 32'(rx_q[3]), 32'h55);
      check("b2b_frame_err", 32'(ferr_cnt), 32'd0);

      // 3-cycle glitch on an idle line
      wait_cycles(10);
      rx = 1'b0;
      wait_cycles(3);
      rx = 1'b1;
      wait_cycles(2);
      check("glitch_busy_rises", 32'(rx_busy), 32'd1);
      wait_cycles(7);
      check("glitch_busy_clears", 32'(rx_busy), 32'd0);
      check("glitch_no_valid", 32'(valid_cnt), 32'd4);
      check("glitch_no_frame_err", 32'(ferr_cnt), 32'd0);

      // stop bit low, then line held low
      wait_cycles(10);
      send_byte(8'h3C, 1'b0);
      wait_cycles(50);
      check("ferr_one_pulse", 32'(ferr_cnt), 32'd1);
      check("ferr_no_valid", 32'(valid_cnt), 32'd4);
      check("ferr_data_held", 32'(rx_data), 32'h55);
      check("ferr_busy_low", 32'(rx_busy), 32'd0);
      rx = 1'b1;
      wait_cycles(10);
      send_byte(8'h81, 1'b1);
      wait_cycles(5);
      check("after_ferr_valid", 32'(valid_cnt), 32'd5);
      check("after_ferr_data", 32'(rx_data), 32'h81);
      check("after_ferr_ferr_count", 32'(ferr_cnt), 32'd1);

      // reset during data bit 4 of 0x96
      wait_cycles(10);
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(1'(8'h96 >> i));
      rx = 1'b1;
      wait_cycles(5);
      #2 rst = 1'b1;
      #1;
      check("midrst_rx_data", 32'(rx_data), 32'h00);
      check("midrst_rx_valid", 32'(rx_valid), 32'd0);
      check("midrst_rx_busy", 32'(rx_busy), 32'd0);
      check("midrst_frame_err", 32'(frame_err), 32'd0);
      wait_cycles(3);
      rst = 1'b0;
      wait_cycles(20);
      check("midrst_no_valid", 32'(valid_cnt), 32'd5);
      send_byte(8'h12, 1'b1);
      wait_cycles(5);
      check("post_rst_valid", 32'(valid_cnt), 32'd6);
      check("post_rst_data", 32'(rx_data), 32'h12);

`ifdef UART_RX_PARITY_EN
      wait_cycles(10);
      par_flip_g = 1'b1;
      send_byte(8'h07, 1'b1);
      wait_cycles(5);
      check("par_bad_perr", 32'(perr_cnt), 32'd1);
      check("par_bad_no_valid", 32'(valid_cnt), 32'd6);
      par_flip_g = 1'b0;
      send_byte(8'h07, 1'b1);
      wait_cycles(5);
      check("par_good_valid", 32'(valid_cnt), 32'd7);
      check("par_good_data", 32'(rx_data), 32'h07);
      check("par_good_perr", 32'(perr_cnt), 32'd1);
`else
      check("no_parity_err", 32'(perr_cnt), 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
